// File: rtl/ula_sequencer.sv
// ula_sequencer
//
// Instruction-issuing front end for the ula arithmetic unit. Packed
// instructions {opcode, operand1, operand2} are accepted over a valid/ready
// handshake into a small FIFO. Each instruction is presented to the ula,
// held for SETTLE_CYCLES cycles, captured with a one-cycle ula_grab strobe
// and returned over a second valid/ready handshake. A divide by zero is
// answered directly with res_error = 1 and never reaches the ula.
//
// Parameters:
//   FIFO_DEPTH     instruction FIFO entries (power of two, 2..16)
//   SETTLE_CYCLES  cycles operands are held before the grab pulse (1..15)
//   DIV_OPCODE     opcode trapped when operand2 == 0
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-low
//   instr_valid    instruction offered
//   instr_ready    FIFO can accept (not full, and out of reset)
//   instr_data     [11:8] opcode, [7:4] operand1, [3:0] operand2
//   ula_operando1  operand1 to ula
//   ula_operando2  operand2 to ula
//   ula_opcode     opcode to ula
//   ula_grab       one-cycle capture strobe to ula
//   ula_result     ula result (combinational from the ula_* outputs)
//   res_valid      result available
//   res_ready      consumer accepts result
//   res_data       captured result
//   res_error      result was a trapped divide-by-zero
//   busy           FSM not idle or FIFO non-empty

module ula_sequencer #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [3:0]  DIV_OPCODE    = 4'd3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [11:0] instr_data,
    output logic [3:0]  ula_operando1,
    output logic [3:0]  ula_operando2,
    output logic [3:0]  ula_opcode,
    output logic        ula_grab,
    input  logic [7:0]  ula_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_error,
    output logic        busy
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GRAB,
        OUTPUT
    } state_t;

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    logic [11:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          rdy_en;

    state_t        state;
    logic [3:0]    settle_cnt;

    logic [11:0]   head;
    logic [3:0]    head_opcode;
    logic [3:0]    head_op1;
    logic [3:0]    head_op2;
    logic          head_trap;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

    // rdy_en keeps instr_ready low for every cycle that reset was sampled low,
    // even though the FIFO itself is empty then.
    assign instr_ready = rdy_en && !full;

    // instr_ready already excludes full, so a push is refused while full
    // even when a pop happens in the same cycle.
    assign push = instr_valid && instr_ready;
    assign pop  = (state == IDLE) && !empty;

    assign head        = mem[rd_ptr];
    assign head_opcode = head[11:8];
    assign head_op1    = head[7:4];
    assign head_op2    = head[3:0];
    assign head_trap   = (head_opcode == DIV_OPCODE) && (head_op2 == 4'd0);

    assign busy = (state != IDLE) || !empty;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // Storage carries no reset; the count and pointers alone define contents.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= instr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM, all outputs registered
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            ula_operando1 <= '0;
            ula_operando2 <= '0;
            ula_opcode    <= '0;
            ula_grab      <= 1'b0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_error     <= 1'b0;
        end else begin
            ula_grab <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head_trap) begin
                            res_data  <= '0;
                            res_error <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= OUTPUT;
                        end else begin
                            ula_opcode    <= head_opcode;
                            ula_operando1 <= head_op1;
                            ula_operando2 <= head_op2;
                            settle_cnt    <= 4'(SETTLE_CYCLES);
                            state         <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        ula_grab <= 1'b1;
                        state    <= GRAB;
                    end
                end

                GRAB: begin
                    res_data  <= ula_result;
                    res_error <= 1'b0;
                    res_valid <= 1'b1;
                    state     <= OUTPUT;
                end

                OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
